// File: rtl/fixed_acc.sv
// Streaming signed fixed-point accumulator: sums cfg_len input beats in a wide register and
// emits one saturated or wrapped WIDTH-bit result per group on a valid/ready output port.
module fixed_acc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LEN_WIDTH = 16,
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    input  logic                 S_vld,
    input  logic [WIDTH-1:0]     S_dat,
    output logic                 S_rdy,
    output logic                 R_vld,
    output logic [WIDTH-1:0]     R_dat,
    output logic                 R_ovf,
    input  logic                 R_rdy,
    output logic                 drop_err
);

    localparam int unsigned AccWidth = WIDTH + LEN_WIDTH;

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e                 state_q, state_d;
    logic [AccWidth-1:0]    acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   r_vld_q, r_vld_d;
    logic [WIDTH-1:0]       r_dat_q, r_dat_d;
    logic                   r_ovf_q, r_ovf_d;
    logic                   drop_q, drop_d;

    logic                   accept;
    logic                   finish;
    logic [LEN_WIDTH-1:0]   len_eff;
    logic [LEN_WIDTH-1:0]   cnt_inc;
    logic [AccWidth-1:0]    beat_ext;
    logic [AccWidth-1:0]    full;
    logic                   ovf;
    logic [WIDTH-1:0]       res;

    assign S_rdy    = !r_vld_q || R_rdy;
    assign R_vld    = r_vld_q;
    assign R_dat    = r_dat_q;
    assign R_ovf    = r_ovf_q;
    assign drop_err = drop_q;

    always_comb begin
        accept   = S_vld && S_rdy;
        len_eff  = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
        cnt_inc  = cnt_q + LEN_WIDTH'(1);
        beat_ext = {{LEN_WIDTH{S_dat[WIDTH-1]}}, S_dat};
        // In idle the running sum is empty, so the group total is the beat itself.
        full     = ((state_q == StAcc) ? acc_q : '0) + beat_ext;

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        finish  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    len_d = len_eff;
                    acc_d = beat_ext;
                    cnt_d = LEN_WIDTH'(1);
                    if (len_eff == LEN_WIDTH'(1)) begin
                        finish = 1'b1;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                if (accept) begin
                    acc_d = full;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        finish  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Result fits in WIDTH bits only when all bits above the WIDTH sign bit match it.
    always_comb begin
        ovf = (full[AccWidth-1:WIDTH-1] != {(LEN_WIDTH + 1){full[AccWidth-1]}});
        res = full[WIDTH-1:0];
        if (SATURATE && ovf) begin
            res = full[AccWidth-1] ? {1'b1, {(WIDTH - 1){1'b0}}}
                                   : {1'b0, {(WIDTH - 1){1'b1}}};
        end
    end

    always_comb begin
        r_vld_d = r_vld_q;
        r_dat_d = r_dat_q;
        r_ovf_d = r_ovf_q;
        if (finish) begin
            r_vld_d = 1'b1;
            r_dat_d = res;
            r_ovf_d = ovf;
        end else if (R_rdy) begin
            r_vld_d = 1'b0;
        end
        drop_d = drop_q | (S_vld && !S_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            r_vld_q <= 1'b0;
            r_dat_q <= '0;
            r_ovf_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            r_vld_q <= r_vld_d;
            r_dat_q <= r_dat_d;
            r_ovf_q <= r_ovf_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fixed_acc.sv
// Directed bench for fixed_acc: a saturating and a wrapping instance share one stimulus stream;
// expected results are queued when the closing beat is driven and checked as they are consumed.
module tb_fixed_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_len;
    logic        S_vld;
    logic [31:0] S_dat;
    logic        R_rdy;

    logic        S_rdy, R_vld, R_ovf, drop_err;
    logic [31:0] R_dat;
    logic        s_rdy_w, r_vld_w, r_ovf_w, drop_w;
    logic [31:0] r_dat_w;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] sd;
        logic        so;
        logic [31:0] wd;
        logic        wo;
    } exp_t;

    exp_t exp_q[$];

    localparam longint MaxV = 64'sd2147483647;
    localparam longint MinV = -64'sd2147483648;

    always #5 clk = ~clk;

    fixed_acc #(.WIDTH(32), .LEN_WIDTH(16), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .S_vld(S_vld), .S_dat(S_dat),
        .S_rdy(S_rdy), .R_vld(R_vld), .R_dat(R_dat), .R_ovf(R_ovf), .R_rdy(R_rdy),
        .drop_err(drop_err)
    );

    fixed_acc #(.WIDTH(32), .LEN_WIDTH(16), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .S_vld(S_vld), .S_dat(S_dat),
        .S_rdy(s_rdy_w), .R_vld(r_vld_w), .R_dat(r_dat_w), .R_ovf(r_ovf_w), .R_rdy(R_rdy),
        .drop_err(drop_w)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for both instances from the exact group total.
    task automatic push_exp(input longint full);
        exp_t e;
        int   w;
        if (full > MaxV) begin
            e.sd = 32'h7FFF_FFFF;
            e.so = 1'b1;
        end else if (full < MinV) begin
            e.sd = 32'h8000_0000;
            e.so = 1'b1;
        end else begin
            e.sd = full[31:0];
            e.so = 1'b0;
        end
        e.wd = full[31:0];
        w    = full[31:0];
        e.wo = (longint'(w) != full);
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [31:0] d);
        S_vld = 1'b1;
        S_dat = d;
        @(posedge clk); #1;
        S_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_rdy"}, 64'(S_rdy), 64'd1);
        check({tag, "_r_vld"}, 64'(R_vld), 64'd0);
        check({tag, "_r_dat"}, 64'(R_dat), 64'd0);
        check({tag, "_r_ovf"}, 64'(R_ovf), 64'd0);
        check({tag, "_drop"},  64'(drop_err), 64'd0);
        check({tag, "_w_vld"}, 64'(r_vld_w), 64'd0);
        check({tag, "_w_drop"}, 64'(drop_w), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && R_vld && R_rdy) begin
            check("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sat_dat",  64'(R_dat),   64'(e.sd));
                check("sat_ovf",  64'(R_ovf),   64'(e.so));
                check("wrap_vld", 64'(r_vld_w), 64'd1);
                check("wrap_dat", 64'(r_dat_w), 64'(e.wd));
                check("wrap_ovf", 64'(r_ovf_w), 64'(e.wo));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        cfg_len = 16'd4;
        S_vld   = 1'b0;
        S_dat   = '0;
        R_rdy   = 1'b1;
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(1);

        // Basic sum, one-cycle latency, single-cycle valid
        cfg_len = 16'd4;
        beat(32'd10);
        beat(-32'sd3);
        beat(32'd7);
        check("basic_not_done", 64'(R_vld), 64'd0);
        push_exp(64'sd15);
        beat(32'd1);
        check("basic_vld", 64'(R_vld), 64'd1);
        idle(1);
        check("basic_vld_drop", 64'(R_vld), 64'd0);

        // Positive and negative overflow
        cfg_len = 16'd2;
        beat(32'h7FFF_FFFF);
        push_exp(64'sd2147483649);
        beat(32'h0000_0002);
        beat(32'h8000_0000);
        push_exp(-64'sd2147483649);
        beat(32'hFFFF_FFFF);
        idle(2);

        // Backpressure: second beat dropped, result held
        cfg_len = 16'd1;
        R_rdy   = 1'b0;
        push_exp(64'sd5);
        beat(32'd5);
        S_vld = 1'b1;
        S_dat = 32'd6;
        check("bp_s_rdy", 64'(S_rdy), 64'd0);
        check("bp_vld", 64'(R_vld), 64'd1);
        @(posedge clk); #1;
        S_vld = 1'b0;
        check("bp_drop", 64'(drop_err), 64'd1);
        check("bp_hold_dat", 64'(R_dat), 64'd5);
        check("bp_wrap_drop", 64'(drop_w), 64'd1);
        R_rdy = 1'b1;
        idle(1);
        check("bp_drop_sticky", 64'(drop_err), 64'd1);
        check("bp_vld_clear", 64'(R_vld), 64'd0);

        // cfg_len = 0 behaves as 1, back-to-back results
        cfg_len = 16'd0;
        push_exp(64'sd9);
        beat(32'd9);
        push_exp(64'sd4);
        beat(32'd4);
        check("len0_second_vld", 64'(R_vld), 64'd1);
        idle(1);

        // Length latched at group start
        cfg_len = 16'd3;
        push_exp(64'sd6);
        beat(32'd1);
        cfg_len = 16'd2;
        beat(32'd2);
        check("len_latched_open", 64'(R_vld), 64'd0);
        beat(32'd3);
        check("len_latched_done", 64'(R_vld), 64'd1);
        idle(1);

        // Reset mid-group discards the partial sum; beat during reset ignored
        cfg_len = 16'd4;
        beat(32'd100);
        beat(32'd200);
        rst   = 1'b1;
        S_vld = 1'b1;
        S_dat = 32'd77;
        @(posedge clk); #1;
        check_reset_outputs("mid_rst");
        rst   = 1'b0;
        S_vld = 1'b0;
        beat(32'd1);
        beat(32'd1);
        beat(32'd1);
        push_exp(64'sd4);
        beat(32'd1);
        check("rst_group_vld", 64'(R_vld), 64'd1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("final_drop_clear", 64'(drop_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fixed_acc.md
# fixed_acc

Streaming signed fixed-point accumulator that sits directly downstream of the fixed-point adder and consumes its sum stream. It adds `cfg_len` consecutive sum beats into a wide internal register, then presents one rounded-to-width (saturated or wrapped) result on a valid/ready output port. It also flags overflow per result and flags, sticky, any input beat that arrives while it is not ready.

## Interface
- `WIDTH`, 32: data width of input beats and of the result, two's complement.
- `LEN_WIDTH`, 16: width of the group-length field; internal accumulator is `WIDTH+LEN_WIDTH` bits.
- `SATURATE`, 1: 1 = clamp the result to the `WIDTH` range; 0 = keep the low `WIDTH` bits (wrap).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_len`  in  LEN_WIDTH  number of terms per group; sampled on the first beat of each group; 0 is treated as 1.
- `S_vld`  in  1  input sum beat valid.
- `S_dat`  in  WIDTH  input sum, signed.
- `S_rdy`  out  1  accumulator can take a beat this cycle.
- `R_vld`  out  1  result valid.
- `R_dat`  out  WIDTH  accumulated result, signed.
- `R_ovf`  out  1  result was clamped (SATURATE=1) or wrapped (SATURATE=0); qualified by `R_vld`.
- `R_rdy`  in  1  downstream accepts the result.
- `drop_err`  out  1  sticky: a beat arrived with `S_vld=1` and `S_rdy=0`; cleared only by `rst`.

## Operation
- A beat is accepted when `S_vld && S_rdy` on a rising edge. A result is consumed when `R_vld && R_rdy`.
- `S_rdy = !R_vld || R_rdy`. The output register is then always free for a group that completes this cycle.
- State machine:
  - IDLE: no group is open. On an accepted beat:
    - latch `len = max(cfg_len,1)`;
    - set `acc = sext(S_dat)` and `cnt = 1`.
    - If `len == 1`, finish (see below) and stay in IDLE. Otherwise go to ACC.
  - ACC: on each accepted beat, set `acc = acc + sext(S_dat)` and `cnt = cnt + 1`. When the incremented `cnt == len`, finish and go to IDLE. If there is no accepted beat, hold.
- Finish:
  - compute `full = acc + sext(S_dat)` (the sum including the current beat), `WIDTH+LEN_WIDTH` bits;
  - register `R_dat` from it and set `R_vld = 1`.
- Width rule with SATURATE=1:
  - `full > 2^(WIDTH-1)-1` gives `R_dat = 2^(WIDTH-1)-1` and `R_ovf = 1`;
  - `full < -2^(WIDTH-1)` gives `R_dat = -2^(WIDTH-1)` and `R_ovf = 1`;
  - otherwise `R_dat = full[WIDTH-1:0]` and `R_ovf = 0`.
- Width rule with SATURATE=0: `R_dat = full[WIDTH-1:0]`, and `R_ovf = 1` when `sext(R_dat) != full`.
- The internal accumulator never overflows for `len <= 2^LEN_WIDTH-1`.
- `R_vld` clears on the cycle after the result is consumed, unless a new result finishes on that same edge. In that case `R_vld` stays 1 and `R_dat`/`R_ovf` take the new values.
- `R_dat`/`R_ovf` are held stable while `R_vld && !R_rdy`.
- `drop_err` sets on any edge with `S_vld && !S_rdy`. The dropped beat does not affect `acc` or `cnt`.
- `cfg_len` changes mid-group have no effect until the next group.

## Timing
- Reset values: `S_rdy = 1`, `R_vld = 0`, `R_dat = 0`, `R_ovf = 0`, `drop_err = 0`. Internal state: IDLE, `acc = 0`, `cnt = 0`.
- `rst` mid-group discards the partial group and any pending result. Beats presented in the reset cycle are not accepted and do not set `drop_err`.
- Latency: the last beat accepted at edge k gives `R_vld = 1` in the cycle after edge k (1 cycle).
- Throughput: one beat per cycle while `R_rdy = 1`. Back-to-back `len = 1` groups produce one result per cycle.
- `R_vld && !R_rdy` forces `S_rdy = 0` the same cycle (combinational from `R_vld`/`R_rdy`).
- Simultaneous events: result consumed plus new group finishing on the same edge means the output is replaced with no bubble. Result consumed plus a mid-group beat means only `acc` updates.

## Test plan
- Basic sum: WIDTH=32, `cfg_len = 4`, beats 10, -3, 7, 1, `R_rdy = 1` -> `R_dat = 15` and `R_ovf = 0` one cycle after the 4th beat; `R_vld` high for 1 cycle.
- Saturation: SATURATE=1, `cfg_len = 2`, beats 0x7FFFFFFF, 0x00000002 -> `R_dat = 0x7FFFFFFF`, `R_ovf = 1`. Beats 0x80000000, 0xFFFFFFFF -> `R_dat = 0x80000000`, `R_ovf = 1`.
- Wrap: SATURATE=0, same positive case -> `R_dat = 0x80000001`, `R_ovf = 1`.
- Backpressure/drop:
  - `cfg_len = 1`, beats 5 then 6 on consecutive cycles with `R_rdy = 0` -> `R_dat = 5` held and `S_rdy = 0` on the second cycle;
  - the dropped beat 6 sets `drop_err = 1`, and it stays 1 after `R_rdy` rises.
- Length edge cases:
  - `cfg_len = 0`, beats 9, 4 -> two results, 9 then 4;
  - `cfg_len` changed from 3 to 2 after the first beat of a group -> the group still takes 3 beats.
- Reset mid-group: `cfg_len = 4`, 2 beats accepted, then `rst` for 1 cycle, then 4 beats of 1 -> `R_dat = 4`, not 4 plus the partial sum; all outputs equal their reset values during reset.
